// File: rtl/sm_accum_sequencer_pkg.sv
// Shared types and default widths for the sign-magnitude accumulate sequencer.
package sm_accum_sequencer_pkg;

  localparam int unsigned DEF_DATA_W = 5;
  localparam int unsigned DEF_ACC_W  = 8;
  localparam int unsigned DEF_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_CONV    = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/sm_accum_sequencer_if.sv
// Operand/result handshake bundle for sm_accum_sequencer.
//  master: operand producer + result consumer; slave: the sequencer.
interface sm_accum_sequencer_if
  import sm_accum_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);
  logic              start;
  logic [CNT_W-1:0]  num_ops;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output start, num_ops, in_valid, in_data, out_ready,
    input  in_ready, busy, out_valid, acc_out, overflow, op_count
  );

  modport slave (
    input  start, num_ops, in_valid, in_data, out_ready,
    output in_ready, busy, out_valid, acc_out, overflow, op_count
  );
endinterface

// File: rtl/sm_to_twos.sv
// Combinational sign-magnitude to two's-complement converter.
//  sm_i   : sign-magnitude operand (MSB = sign)
//  twos_c : two's-complement value; negative zero maps to 0
module sm_to_twos #(
  parameter int unsigned DATA_W = 5
) (
  input  logic [DATA_W-1:0] sm_i,
  output logic [DATA_W-1:0] twos_c
);
  logic              sign;
  logic [DATA_W-2:0] mag;

  always_comb begin
    sign = sm_i[DATA_W-1];
    mag  = sm_i[DATA_W-2:0];
    // Negation as invert-plus-one; -0 wraps to 0 naturally.
    if (sign) twos_c = {1'b1, ~mag} + DATA_W'(1);
    else      twos_c = {1'b0, mag};
  end
endmodule

// File: rtl/sm_accum_sequencer.sv
// Burst sequencer: accepts num_ops sign-magnitude operands, converts each to
// two's complement and accumulates them, then presents the sum with a sticky
// signed-overflow flag.
//  clk, rst_n : clock, async active-low reset
//  bus        : slave side of sm_accum_sequencer_if (start/num_ops, operand
//               valid/ready, result valid/ready, acc_out/overflow/op_count, busy)
module sm_accum_sequencer
  import sm_accum_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst_n,
  sm_accum_sequencer_if.slave bus
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] conv_q, conv_d, conv_c;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  value_ext_c, sum_c;
  logic              overflow_q, overflow_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;

  sm_to_twos #(.DATA_W(DATA_W)) u_sm_to_twos (
    .sm_i   (operand_q),
    .twos_c (conv_c)
  );

  // Sign-extended converted operand and the wrapping sum.
  always_comb begin
    value_ext_c = ACC_W'($signed(conv_q));
    sum_c       = acc_q + value_ext_c;
  end

  // Next-state and datapath updates; status outputs are decoded from the
  // next state so they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    operand_d   = operand_q;
    conv_d      = conv_q;
    remaining_d = remaining_q;
    op_count_d  = op_count_q;
    acc_d       = acc_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.num_ops;
          acc_d       = '0;
          overflow_d  = 1'b0;
          op_count_d  = '0;
          state_d     = (bus.num_ops == '0) ? ST_DONE : ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (bus.in_valid && in_ready_q) begin
          operand_d = bus.in_data;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        conv_d  = conv_c;
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        acc_d       = sum_c;
        // Like-signed addends producing an opposite-signed sum.
        overflow_d  = overflow_q |
                      ((acc_q[ACC_W-1] == value_ext_c[ACC_W-1]) &&
                       (sum_c[ACC_W-1] != acc_q[ACC_W-1]));
        op_count_d  = op_count_q + CNT_W'(1);
        remaining_d = remaining_q - CNT_W'(1);
        state_d     = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_WAIT_IN;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_WAIT_IN);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      operand_q   <= '0;
      conv_q      <= '0;
      remaining_q <= '0;
      op_count_q  <= '0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      conv_q      <= conv_d;
      remaining_q <= remaining_d;
      op_count_q  <= op_count_d;
      acc_q       <= acc_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = overflow_q;
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_sm_accum_sequencer.sv
// Scoreboard bench: two sequencers (ACC_W=8 and ACC_W=6) share one stimulus
// stream; expected results come from an integer-arithmetic reference model.
module tb_sm_accum_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_accum_sequencer_if #(.DATA_W(5), .ACC_W(8), .CNT_W(4)) if8 ();
  sm_accum_sequencer_if #(.DATA_W(5), .ACC_W(6), .CNT_W(4)) if6 ();

  assign if6.start     = if8.start;
  assign if6.num_ops   = if8.num_ops;
  assign if6.in_valid  = if8.in_valid;
  assign if6.in_data   = if8.in_data;
  assign if6.out_ready = if8.out_ready;

  sm_accum_sequencer #(.DATA_W(5), .ACC_W(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8));
  sm_accum_sequencer #(.DATA_W(5), .ACC_W(6), .CNT_W(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(if6));

  typedef struct {
    logic [7:0] acc;
    logic       ovf;
    logic [3:0] cnt;
  } res_t;

  res_t q8[$];
  res_t q6[$];
  res_t e8, e6;
  int vec = 0;
  int miss = 0;
  bit seen8 = 1'b0;
  bit seen6 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true integer sum, wrapped to w bits after each addition;
  // overflow whenever the exact sum leaves the signed w-bit range.
  function automatic res_t model(input int ops[$], input int w);
    res_t r;
    int m, hi, lo, acc, s, mag, v;
    bit ovf;
    m = 1 << w; hi = m / 2 - 1; lo = -(m / 2); acc = 0; ovf = 1'b0;
    foreach (ops[i]) begin
      mag = ops[i] % 16;
      v   = (ops[i] >= 16) ? -mag : mag;
      s   = acc + v;
      if (s > hi || s < lo) ovf = 1'b1;
      if (s > hi) s -= m;
      else if (s < lo) s += m;
      acc = s;
    end
    r.acc = 8'(acc & (m - 1));
    r.ovf = ovf;
    r.cnt = 4'(ops.size());
    return r;
  endfunction

  // Monitors: compare once on the first cycle each result is presented.
  always @(negedge clk) begin
    if (!rst_n || !if8.out_valid) seen8 = 1'b0;
    else if (!seen8) begin
      seen8 = 1'b1;
      if (q8.size() == 0) check("unexpected_result8", 1, 0);
      else begin
        e8 = q8.pop_front();
        check("acc8", 32'(if8.acc_out), 32'(e8.acc));
        check("ovf8", 32'(if8.overflow), 32'(e8.ovf));
        check("cnt8", 32'(if8.op_count), 32'(e8.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || !if6.out_valid) seen6 = 1'b0;
    else if (!seen6) begin
      seen6 = 1'b1;
      if (q6.size() == 0) check("unexpected_result6", 1, 0);
      else begin
        e6 = q6.pop_front();
        check("acc6", 32'(if6.acc_out), 32'(e6.acc));
        check("ovf6", 32'(if6.overflow), 32'(e6.ovf));
        check("cnt6", 32'(if6.op_count), 32'(e6.cnt));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input int ops[$]);
    q8.push_back(model(ops, 8));
    q6.push_back(model(ops, 6));
  endtask

  task automatic start_burst(input int n);
    if8.start   = 1'b1;
    if8.num_ops = 4'(n);
    cyc();
    if8.start = 1'b0;
  endtask

  task automatic send_op(input int d);
    int t = 0;
    if8.in_valid = 1'b1;
    if8.in_data  = 5'(d);
    while (!if8.in_ready && t < 50) begin cyc(); t++; end
    if (t >= 50) check("in_ready_timeout", 0, 1);
    else cyc();
    if8.in_valid = 1'b0;
    if8.in_data  = 5'($urandom);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!if8.out_valid && t < 50) begin cyc(); t++; end
    if (t >= 50) check("out_valid_timeout", 0, 1);
  endtask

  task automatic take_result(input int hold);
    wait_valid();
    repeat (hold) cyc();
    if8.out_ready = 1'b1;
    cyc();
    if8.out_ready = 1'b0;
  endtask

  task automatic run_burst(input int ops[$], input int hold, input int gap);
    push_expect(ops);
    start_burst(ops.size());
    foreach (ops[i]) begin
      repeat (gap) cyc();
      send_op(ops[i]);
    end
    take_result(hold);
  endtask

  initial begin
    int ops[$];
    int n;
    if8.start = 1'b0; if8.num_ops = '0; if8.in_valid = 1'b0;
    if8.in_data = '0; if8.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", 32'(if8.acc_out), 0);
    check("rst_busy", 32'(if8.busy), 0);
    check("rst_in_ready", 32'(if8.in_ready), 0);
    check("rst_out_valid", 32'(if8.out_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // Mixed signs, plus accept-to-result latency
    ops = '{5'b00101, 5'b10011, 5'b01111};
    push_expect(ops);
    start_burst(3);
    foreach (ops[i]) send_op(ops[i]);
    check("lat_c1", 32'(if8.out_valid), 0);
    cyc();
    check("lat_c2", 32'(if8.out_valid), 0);
    cyc();
    check("lat_c3", 32'(if8.out_valid), 1);
    check("t1_acc", 32'(if8.acc_out), 32'h11);
    take_result(0);

    // Negative zero and the most negative magnitude
    run_burst('{5'b10000, 5'b11111}, 0, 0);

    // Narrow accumulator wraps and flags overflow
    run_burst('{5'b01111, 5'b01111, 5'b01111}, 1, 0);
    check("t3_acc6_last", 32'(if6.acc_out), 32'h2D);
    check("t3_ovf6_last", 32'(if6.overflow), 1);

    // Empty burst goes straight to DONE
    push_expect('{});
    start_burst(0);
    check("t4_valid", 32'(if8.out_valid), 1);
    check("t4_cnt", 32'(if8.op_count), 0);
    take_result(0);

    // Stalled producer, start while busy, stalled consumer
    ops = '{5'b00011, 5'b10111};
    push_expect(ops);
    start_burst(2);
    for (int i = 0; i < 5; i++) begin
      if8.start   = (i == 2);
      if8.num_ops = 4'd9;
      cyc();
      check("t5_in_ready", 32'(if8.in_ready), 1);
      check("t5_cnt_idle", 32'(if8.op_count), 0);
    end
    if8.start = 1'b0;
    foreach (ops[i]) send_op(ops[i]);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t5_hold_valid", 32'(if8.out_valid), 1);
      check("t5_hold_acc", 32'(if8.acc_out), 32'hFC);
      check("t5_hold_cnt", 32'(if8.op_count), 2);
    end
    if8.out_ready = 1'b1;
    cyc();
    if8.out_ready = 1'b0;
    check("t5_valid_drop", 32'(if8.out_valid), 0);
    check("t5_busy_drop", 32'(if8.busy), 0);
    check("t5_acc_kept", 32'(if8.acc_out), 32'hFC);

    // Asynchronous reset mid-burst
    start_burst(3);
    send_op(5'b00110);
    send_op(5'b00010);
    check("t6_cnt_pre", 32'(if8.op_count), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_acc", 32'(if8.acc_out), 0);
    check("t6_cnt", 32'(if8.op_count), 0);
    check("t6_busy", 32'(if8.busy), 0);
    check("t6_ovf6", 32'(if6.overflow), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    run_burst('{5'b00001}, 0, 0);

    // Randomized bursts
    for (int b = 0; b < 25; b++) begin
      ops.delete();
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) ops.push_back($urandom_range(0, 31));
      run_burst(ops, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    repeat (3) cyc();
    check("q8_drained", q8.size(), 0);
    check("q6_drained", q6.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
